mosi_command_sequencer: RTL



---
 rtl/mosi_seq_pkg.sv | 18 +
 rtl/spi_word_tx.sv | 116 +++++++++++
 rtl/mosi_command_sequencer.sv | 108 ++++++++++
 3 files changed

// File: rtl/mosi_seq_pkg.sv
// Shared types and default widths for the MOSI command sequencer.
package mosi_seq_pkg;

  localparam int ADDR_W_DEF = 10;
  localparam int CMD_W_DEF  = 16;

  // The top walks IDLE/FETCH/LOAD; the word transmitter walks SETUP..GAP.
  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    LOAD,
    SETUP,
    SHIFT,
    HOLD,
    GAP
  } state_t;

endpackage

// File: rtl/spi_word_tx.sv
// SPI mode-0 word transmitter: frames one command word MSB-first with
// chip-select setup, hold and inter-frame gap, each CLK_DIV clocks long.
module spi_word_tx
  import mosi_seq_pkg::*;
#(
  parameter int CMD_W   = CMD_W_DEF,
  parameter int CLK_DIV = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [CMD_W-1:0] word,
  output logic             cs_n,
  output logic             sclk,
  output logic             mosi,
  output logic             done
);

  localparam int HW = $clog2(CLK_DIV + 1);
  localparam int BW = $clog2(CMD_W + 1);

  localparam logic [HW-1:0] HALF_LAST = HW'(CLK_DIV - 1);
  // Count value one before the last GAP clock, so the registered done
  // lands exactly on that last clock.
  localparam logic [HW-1:0] DONE_AT   = HW'(CLK_DIV - 2);
  localparam logic [BW-1:0] BIT_LAST  = BW'(CMD_W - 1);

  state_t           state;
  logic [HW-1:0]    half_cnt;
  logic [BW-1:0]    bit_cnt;
  // Holds the bits still to be sent, left-aligned; the bit on the wire
  // lives in mosi, so the register already excludes it.
  logic [CMD_W-1:0] shift_reg;

  // Frame sequencer: counts half-periods, toggles sclk and shifts on falls.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      half_cnt  <= '0;
      bit_cnt   <= '0;
      shift_reg <= '0;
      cs_n      <= 1'b1;
      sclk      <= 1'b0;
      mosi      <= 1'b0;
      done      <= 1'b0;
    end else begin
      // NOTE: every register here uses <= so all of them update from the
      // same pre-edge values; a blocking = would leak new values forward.
      done <= 1'b0;
      case (state)
        SETUP: begin
          if (half_cnt == HALF_LAST) begin
            state    <= SHIFT;
            half_cnt <= '0;
            bit_cnt  <= '0;
          end else begin
            half_cnt <= half_cnt + 1'b1;
          end
        end
        SHIFT: begin
          if (half_cnt == HALF_LAST) begin
            half_cnt <= '0;
            if (!sclk) begin
              sclk <= 1'b1;
            end else begin
              // End of the high phase: data advances on the falling edge.
              sclk              <= 1'b0;
              {mosi, shift_reg} <= {shift_reg, 1'b0};
              if (bit_cnt == BIT_LAST) begin
                state   <= HOLD;
                bit_cnt <= '0;
              end else begin
                bit_cnt <= bit_cnt + 1'b1;
              end
            end
          end else begin
            half_cnt <= half_cnt + 1'b1;
          end
        end
        HOLD: begin
          if (half_cnt == HALF_LAST) begin
            state    <= GAP;
            half_cnt <= '0;
            cs_n     <= 1'b1;
            done     <= (CLK_DIV == 1);
          end else begin
            half_cnt <= half_cnt + 1'b1;
          end
        end
        GAP: begin
          if (half_cnt == HALF_LAST) begin
            state    <= IDLE;
            half_cnt <= '0;
          end else begin
            half_cnt <= half_cnt + 1'b1;
            done     <= (half_cnt == DONE_AT);
          end
        end
        // NOTE: a default arm keeps the case complete, so no state value
        // can leave a register without a defined next value.
        default: begin
          if (load) begin
            state     <= SETUP;
            half_cnt  <= '0;
            bit_cnt   <= '0;
            shift_reg <= {word[CMD_W-2:0], 1'b0};
            cs_n      <= 1'b0;
            sclk      <= 1'b0;
            mosi      <= word[CMD_W-1];
          end
        end
      endcase
    end
  end

endmodule

// File: rtl/mosi_command_sequencer.sv
// Walks the MOSI command RAM from address 0 to max_index, fetching each
// word over the synchronous read port and handing it to the SPI transmitter.
module mosi_command_sequencer
  import mosi_seq_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int CMD_W   = CMD_W_DEF,
  parameter int CLK_DIV = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              stop,
  input  logic              loop_en,
  input  logic [ADDR_W-1:0] max_index,
  output logic [ADDR_W-1:0] ram_addr,
  input  logic [CMD_W-1:0]  ram_data,
  output logic              busy,
  output logic [ADDR_W-1:0] cmd_index,
  output logic              cs_n,
  output logic              sclk,
  output logic              mosi,
  output logic              cmd_done,
  output logic              seq_done
);

  state_t            state;
  logic [ADDR_W-1:0] max_idx;
  logic              stop_seen;
  logic              tx_load;

  // RAM data is valid during LOAD, so the transmitter takes it on that edge.
  assign tx_load = (state == LOAD);

  spi_word_tx #(
    .CMD_W   (CMD_W),
    .CLK_DIV (CLK_DIV)
  ) u_tx (
    .clk   (clk),
    .reset (reset),
    .load  (tx_load),
    .word  (ram_data),
    .cs_n  (cs_n),
    .sclk  (sclk),
    .mosi  (mosi),
    .done  (cmd_done)
  );

  // Address sequencing, loop/stop decisions and the busy/seq_done flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      ram_addr  <= '0;
      cmd_index <= '0;
      max_idx   <= '0;
      stop_seen <= 1'b0;
      busy      <= 1'b0;
      seq_done  <= 1'b0;
    end else begin
      seq_done <= 1'b0;
      if (state != IDLE && stop) begin
        stop_seen <= 1'b1;
      end
      case (state)
        IDLE: begin
          if (start) begin
            ram_addr  <= '0;
            max_idx   <= max_index;
            busy      <= 1'b1;
            // A stop arriving with the start still allows one command.
            stop_seen <= stop;
            state     <= FETCH;
          end
        end
        FETCH: begin
          state <= LOAD;
        end
        LOAD: begin
          cmd_index <= ram_addr;
          state     <= SETUP;
        end
        default: begin
          // The transmitter owns the frame; wait for its last GAP clock.
          if (cmd_done) begin
            if (stop_seen || stop) begin
              state     <= IDLE;
              busy      <= 1'b0;
              seq_done  <= 1'b1;
              stop_seen <= 1'b0;
            end else if (cmd_index != max_idx) begin
              ram_addr <= cmd_index + 1'b1;
              state    <= FETCH;
            end else if (loop_en) begin
              ram_addr <= '0;
              state    <= FETCH;
            end else begin
              state     <= IDLE;
              busy      <= 1'b0;
              seq_done  <= 1'b1;
              stop_seen <= 1'b0;
            end
          end
        end
      endcase
    end
  end

endmodule
